// File: rtl/sprite_anim_ctrl.sv
// Sprite animation controller: button-driven movement, walk/death animation, respawn protection
// and sprite ROM addressing. Define SPRITE_ANIM_BLINK_EN to blink the sprite while protected.
module sprite_anim_ctrl #(
  parameter int unsigned SPR_W     = 16,
  parameter int unsigned SPR_H     = 24,
  parameter int unsigned HB_OFF    = 8,
  parameter int unsigned WALK_FR   = 3,
  parameter int unsigned DEATH_FR  = 4,
  parameter int unsigned MOVE_DIV  = 1200000,
  parameter int unsigned FRAME_DIV = 12500000,
  parameter int unsigned MIN_X     = 48,
  parameter int unsigned MIN_Y     = 24,
  parameter int unsigned MAX_X     = 561,
  parameter int unsigned MAX_Y     = 440,
  parameter int unsigned INIT_X    = 64,
  parameter int unsigned INIT_Y    = 24,
  parameter int unsigned ROM_AW    = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              L,
  input  logic              R,
  input  logic              U,
  input  logic              D,
  input  logic [1:0]        cd,
  input  logic              blk,
  input  logic              hit,
  input  logic              gameover,
  output logic [9:0]        x_s,
  output logic [9:0]        y_s,
  output logic              spr_on,
  output logic              hb_on,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [1:0]        st,
  output logic              death_done
);

  typedef enum logic [1:0] {
    StAlive   = 2'b00,
    StDying   = 2'b01,
    StRespawn = 2'b10,
    StDead    = 2'b11
  } st_e;

  localparam int unsigned MvW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int unsigned FrW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int unsigned FW  = (WALK_FR > 1) ? $clog2(WALK_FR) : 1;
  localparam int unsigned DW  = (DEATH_FR > 1) ? $clog2(DEATH_FR) : 1;
  localparam int unsigned PW  = $clog2(4 * FRAME_DIV + 1);

  localparam logic [MvW-1:0] MvMax    = MvW'(MOVE_DIV - 1);
  localparam logic [FrW-1:0] FrMax    = FrW'(FRAME_DIV - 1);
  localparam logic [FW-1:0]  FMax     = FW'(WALK_FR - 1);
  localparam logic [DW-1:0]  DMax     = DW'(DEATH_FR - 1);
  localparam logic [PW-1:0]  ProtInit = PW'(4 * FRAME_DIV);
  localparam logic [9:0]     MinX     = 10'(MIN_X);
  localparam logic [9:0]     MinY     = 10'(MIN_Y);
  localparam logic [9:0]     MaxX     = 10'(MAX_X);
  localparam logic [9:0]     MaxY     = 10'(MAX_Y);
  localparam logic [9:0]     InitX    = 10'(INIT_X);
  localparam logic [9:0]     InitY    = 10'(INIT_Y);

  st_e            st_q, st_d;
  logic [9:0]     x_q, x_d, y_q, y_d;
  logic [MvW-1:0] mv_q, mv_d;
  logic [FrW-1:0] fr_q, fr_d;
  logic [FW-1:0]  f_q, f_d;
  logic [DW-1:0]  dth_q, dth_d;
  logic [PW-1:0]  prot_q, prot_d;
  logic           done_q, done_d;

  logic btn, mv_tick, fr_wrap, blink;

  assign btn     = L | R | U | D;
  assign mv_tick = (mv_q == MvMax);
  assign fr_wrap = (fr_q == FrMax);

  always_comb begin
    st_d   = st_q;
    x_d    = x_q;
    y_d    = y_q;
    mv_d   = mv_q;
    fr_d   = fr_q;
    f_d    = f_q;
    dth_d  = dth_q;
    prot_d = prot_q;
    done_d = 1'b0;
    unique case (st_q)
      StAlive, StRespawn: begin
        if (btn) begin
          mv_d = mv_tick ? '0 : mv_q + MvW'(1);
          fr_d = fr_wrap ? '0 : fr_q + FrW'(1);
          if (fr_wrap) f_d = (f_q == FMax) ? '0 : f_q + FW'(1);
          if (mv_tick && !blk) begin
            unique case (cd)
              2'b00:   if (y_q > MinY) y_d = y_q - 10'd1;
              2'b01:   if (x_q < MaxX) x_d = x_q + 10'd1;
              2'b10:   if (y_q < MaxY) y_d = y_q + 10'd1;
              default: if (x_q > MinX) x_d = x_q - 10'd1;
            endcase
          end
        end else begin
          mv_d = '0;
          fr_d = '0;
          f_d  = '0;
        end
        if (st_q == StRespawn) begin
          prot_d = prot_q - PW'(1);
          if (prot_q <= PW'(1)) begin
            prot_d = '0;
            st_d   = StAlive;
          end
        end
        // hit outranks gameover so the death sequence still plays before DEAD
        if (st_q == StAlive && hit) begin
          st_d  = StDying;
          x_d   = x_q;
          y_d   = y_q;
          mv_d  = '0;
          fr_d  = '0;
          f_d   = '0;
          dth_d = '0;
        end else if (gameover) begin
          st_d   = StDead;
          x_d    = x_q;
          y_d    = y_q;
          mv_d   = '0;
          fr_d   = '0;
          prot_d = '0;
          dth_d  = DMax;
        end
      end
      StDying: begin
        mv_d = '0;
        fr_d = fr_wrap ? '0 : fr_q + FrW'(1);
        if (fr_wrap) begin
          if (dth_q == DMax) begin
            done_d = 1'b1;
            if (gameover) begin
              st_d = StDead;
            end else begin
              st_d   = StRespawn;
              x_d    = InitX;
              y_d    = InitY;
              prot_d = ProtInit;
            end
          end else begin
            dth_d = dth_q + DW'(1);
          end
        end
      end
      default: begin
        mv_d = '0;
        fr_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q   <= StAlive;
      x_q    <= InitX;
      y_q    <= InitY;
      mv_q   <= '0;
      fr_q   <= '0;
      f_q    <= '0;
      dth_q  <= '0;
      prot_q <= '0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      x_q    <= x_d;
      y_q    <= y_d;
      mv_q   <= mv_d;
      fr_q   <= fr_d;
      f_q    <= f_d;
      dth_q  <= dth_d;
      prot_q <= prot_d;
      done_q <= done_d;
    end
  end

`ifdef SPRITE_ANIM_BLINK_EN
  assign blink = (st_q == StRespawn) && ((32'(prot_q) / FRAME_DIV) % 2 == 1);
`else
  assign blink = 1'b0;
`endif

  logic [31:0] dx, dy, row_idx, col;
  logic        in_x, in_y, in_hb, dying;

  // Offsets wrap to huge values left of / above the sprite, so one unsigned compare suffices.
  always_comb begin
    dx    = 32'(x) - 32'(x_q);
    dy    = 32'(y) - 32'(y_q);
    in_x  = dx < SPR_W;
    in_y  = dy < SPR_H;
    in_hb = (dy >= HB_OFF) && in_y;
    dying = (st_q == StDying) || (st_q == StDead);
    if (dying) begin
      row_idx = 3 * WALK_FR + 32'(dth_q);
    end else begin
      unique case (cd)
        2'b00:   row_idx = 32'(f_q);
        2'b10:   row_idx = 2 * WALK_FR + 32'(f_q);
        default: row_idx = WALK_FR + 32'(f_q);
      endcase
    end
    col      = (cd == 2'b11) ? SPR_W - 1 - dx : dx;
    rom_addr = ROM_AW'((dy + row_idx * SPR_H) * SPR_W + col);
    spr_on   = in_x && in_y && !blink;
    hb_on    = in_x && in_hb && !dying;
  end

  assign x_s        = x_q;
  assign y_s        = y_q;
  assign st         = st_q;
  assign death_done = done_q;

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// Bench for sprite_anim_ctrl: directed scenarios plus randomized stimulus against a cycle-count
// reference model. Honours SPRITE_ANIM_BLINK_EN the same way as the design.
module tb_sprite_anim_ctrl;
  localparam int SPR_W = 16, SPR_H = 24, HB_OFF = 8, WALK_FR = 3, DEATH_FR = 4;
  localparam int MOVE_DIV = 4, FRAME_DIV = 8;
  localparam int MIN_X = 48, MIN_Y = 24, MAX_X = 561, MAX_Y = 440;
  localparam int INIT_X = 64, INIT_Y = 24, ROM_AW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [9:0]        x, y;
  logic              L, R, U, D;
  logic [1:0]        cd;
  logic              blk, hit, gameover;
  logic [9:0]        x_s, y_s;
  logic              spr_on, hb_on;
  logic [ROM_AW-1:0] rom_addr;
  logic [1:0]        st;
  logic              death_done;

  sprite_anim_ctrl #(
    .SPR_W(SPR_W), .SPR_H(SPR_H), .HB_OFF(HB_OFF), .WALK_FR(WALK_FR), .DEATH_FR(DEATH_FR),
    .MOVE_DIV(MOVE_DIV), .FRAME_DIV(FRAME_DIV), .MIN_X(MIN_X), .MIN_Y(MIN_Y), .MAX_X(MAX_X),
    .MAX_Y(MAX_Y), .INIT_X(INIT_X), .INIT_Y(INIT_Y), .ROM_AW(ROM_AW)
  ) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .L(L), .R(R), .U(U), .D(D), .cd(cd), .blk(blk),
    .hit(hit), .gameover(gameover), .x_s(x_s), .y_s(y_s), .spr_on(spr_on), .hb_on(hb_on),
    .rom_addr(rom_addr), .st(st), .death_done(death_done)
  );

  int total = 0;
  int bad = 0;

  // Model: state code, position, cycles buttons held, cycles spent dying, protect cycles left.
  int m_st, m_x, m_y, m_held, m_dcyc, m_prot;
  bit m_done;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic move_one();
    case (cd)
      2'd0: m_y = (m_y > MIN_Y) ? m_y - 1 : m_y;
      2'd1: m_x = (m_x < MAX_X) ? m_x + 1 : m_x;
      2'd2: m_y = (m_y < MAX_Y) ? m_y + 1 : m_y;
      default: m_x = (m_x > MIN_X) ? m_x - 1 : m_x;
    endcase
  endtask

  task automatic model_step();
    m_done = 1'b0;
    if (reset) begin
      m_st = 0; m_x = INIT_X; m_y = INIT_Y; m_held = 0; m_dcyc = 0; m_prot = 0;
      return;
    end
    case (m_st)
      0, 2: begin
        if (m_st == 0 && hit) begin
          m_st = 1; m_dcyc = 0; m_held = 0;
        end else if (gameover) begin
          m_st = 3; m_held = 0;
        end else begin
          if (L | R | U | D) begin
            m_held++;
            if (m_held % MOVE_DIV == 0 && !blk) move_one();
          end else begin
            m_held = 0;
          end
          if (m_st == 2) begin
            m_prot--;
            if (m_prot == 0) m_st = 0;
          end
        end
      end
      1: begin
        m_dcyc++;
        if (m_dcyc == DEATH_FR * FRAME_DIV) begin
          m_done = 1'b1;
          if (gameover) m_st = 3;
          else begin
            m_st = 2; m_x = INIT_X; m_y = INIT_Y; m_prot = 4 * FRAME_DIV; m_held = 0;
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare();
    int dx, dy, row, col, addr, dir;
    bit e_spr, e_hb, blink;
    dx = int'(x) - m_x;
    dy = int'(y) - m_y;
    blink = 1'b0;
`ifdef SPRITE_ANIM_BLINK_EN
    blink = (m_st == 2) && ((m_prot / FRAME_DIV) % 2 == 1);
`endif
    e_spr = dx >= 0 && dx < SPR_W && dy >= 0 && dy < SPR_H && !blink;
    e_hb  = dx >= 0 && dx < SPR_W && dy >= HB_OFF && dy < SPR_H && (m_st == 0 || m_st == 2);
    dir = (cd == 2'd0) ? 0 : (cd == 2'd2) ? 2 : 1;
    if (m_st == 1) row = 3 * WALK_FR + m_dcyc / FRAME_DIV;
    else if (m_st == 3) row = 3 * WALK_FR + DEATH_FR - 1;
    else row = dir * WALK_FR + (m_held / FRAME_DIV) % WALK_FR;
    col  = (cd == 2'd3) ? SPR_W - 1 - dx : dx;
    addr = ((dy + row * SPR_H) * SPR_W + col) % (1 << ROM_AW);
    check_val("st", 32'(st), 32'(m_st));
    check_val("x_s", 32'(x_s), 32'(m_x));
    check_val("y_s", 32'(y_s), 32'(m_y));
    check_val("death_done", 32'(death_done), 32'(m_done));
    check_val("spr_on", 32'(spr_on), 32'(e_spr));
    check_val("hb_on", 32'(hb_on), 32'(e_hb));
    if (e_spr) check_val("rom_addr", 32'(rom_addr), 32'(addr));
  endtask

  task automatic pick_pixel();
    if ($urandom_range(0, 3) == 0) begin
      x = 10'($urandom);
      y = 10'($urandom);
    end else begin
      x = 10'(m_x + int'($urandom_range(0, SPR_W + 3)) - 2);
      y = 10'(m_y + int'($urandom_range(0, SPR_H + 3)) - 2);
    end
  endtask

  // Called just after a falling edge with inputs set; leaves time just after the next one.
  task automatic run(input int n);
    repeat (n) begin
      pick_pixel();
      #1 compare();
      @(posedge clk);
      model_step();
      @(negedge clk);
    end
  endtask

  initial begin
    int hold_left, dead_cnt;
    bit go_hold;
    reset = 1'b1; x = '0; y = '0; {L, R, U, D} = 4'b0; cd = 2'd0;
    blk = 1'b0; hit = 1'b0; gameover = 1'b0;
    m_st = 0; m_x = INIT_X; m_y = INIT_Y; m_held = 0; m_dcyc = 0; m_prot = 0; m_done = 1'b0;
    @(posedge clk);
    model_step();
    @(negedge clk);
    run(1);
    reset = 1'b0;
    check_val("rst_st", 32'(st), 32'd0);
    check_val("rst_x", 32'(x_s), 32'd64);
    check_val("rst_y", 32'(y_s), 32'd24);
    check_val("rst_done", 32'(death_done), 32'd0);

    // Walk right for 40 clocks.
    R = 1'b1; cd = 2'd1;
    run(40);
    check_val("walk_r_x", 32'(x_s), 32'd74);
    check_val("walk_r_y", 32'(y_s), 32'd24);

    // Walk left into the left limit, then inspect the mirrored ROM address.
    R = 1'b0; L = 1'b1; cd = 2'd3;
    run(120);
    check_val("left_sat_x", 32'(x_s), 32'd48);
    L = 1'b0;
    run(1);
    x = 10'd48; y = 10'd24;
    #1 check_val("mirror_addr", 32'(rom_addr), 32'd1167);

    // Death, respawn, protection.
    hit = 1'b1; run(1); hit = 1'b0;
    check_val("dying_st", 32'(st), 32'd1);
    run(31);
    check_val("dying_hold", 32'(st), 32'd1);
    run(1);
    check_val("respawn_st", 32'(st), 32'd2);
    check_val("done_pulse", 32'(death_done), 32'd1);
    check_val("respawn_x", 32'(x_s), 32'd64);
    check_val("respawn_y", 32'(y_s), 32'd24);
    hit = 1'b1; run(31);
    check_val("protect_st", 32'(st), 32'd2);
    hit = 1'b0; run(1);
    check_val("alive_again", 32'(st), 32'd0);

    // hit together with gameover.
    hit = 1'b1; gameover = 1'b1; run(1); hit = 1'b0;
    check_val("hit_go_st", 32'(st), 32'd1);
    run(32);
    check_val("dead_st", 32'(st), 32'd3);
    R = 1'b1; cd = 2'd1; run(10);
    check_val("dead_frozen_x", 32'(x_s), 32'd64);
    R = 1'b0; gameover = 1'b0; reset = 1'b1; run(1); reset = 1'b0;
    check_val("dead_reset_st", 32'(st), 32'd0);

    // Blocked movement, then reset in mid death sequence.
    U = 1'b1; cd = 2'd2; blk = 1'b1; run(20);
    check_val("blocked_y", 32'(y_s), 32'd24);
    U = 1'b0; blk = 1'b0;
    hit = 1'b1; run(1); hit = 1'b0; run(10);
    check_val("mid_dying_st", 32'(st), 32'd1);
    reset = 1'b1; run(1); reset = 1'b0;
    check_val("abort_st", 32'(st), 32'd0);

    // Randomized phase.
    hold_left = 0; dead_cnt = 0; go_hold = 1'b0;
    repeat (3000) begin
      if (hold_left == 0) begin
        hold_left = int'($urandom_range(1, 40));
        {L, R, U, D} = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'(1 << $urandom_range(0, 3));
        cd  = 2'($urandom_range(0, 3));
        blk = ($urandom_range(0, 4) == 0);
      end
      hold_left--;
      hit = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 499) == 0) go_hold = 1'b1;
      gameover = go_hold;
      dead_cnt = (m_st == 3) ? dead_cnt + 1 : 0;
      reset = ($urandom_range(0, 599) == 0) || dead_cnt > 20;
      if (reset) go_hold = 1'b0;
      run(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
